// File: rtl/execution_controller.sv
// ============================================================================
// execution_controller : run/step sequencer and HALT drain for the MIPS pipe
// Rev 1.0
// ============================================================================
`default_nettype none

module execution_controller #(
  parameter int                N_BITS        = 32,
  parameter int                N_BITS_CYCLES = 32,
  parameter logic [N_BITS-1:0] HALT_WORD     = {N_BITS{1'b1}},
  parameter int                DRAIN_CYCLES  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_cmd_valid,
  input  logic [1:0]               i_cmd,
  output logic                     o_cmd_ready,
  input  logic                     i_instr_valid,
  input  logic [N_BITS-1:0]        i_instruccion,
  output logic                     o_pipe_enable,
  output logic                     o_fetch_enable,
  output logic                     o_pipe_reset,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_aborted,
  output logic                     o_dump_req,
  output logic [N_BITS_CYCLES-1:0] o_cycle_count,
  output logic [1:0]               o_state
);

  localparam logic [1:0] c_ST_IDLE = 2'b00;
  localparam logic [1:0] c_ST_RUN  = 2'b01;
  localparam logic [1:0] c_ST_STEP = 2'b10;
  localparam logic [1:0] c_ST_DONE = 2'b11;

  localparam logic [1:0] c_CMD_RUN   = 2'b01;
  localparam logic [1:0] c_CMD_STEP  = 2'b10;
  localparam logic [1:0] c_CMD_ABORT = 2'b11;

  localparam logic [3:0] c_DRAIN_INIT = 4'(DRAIN_CYCLES);

  logic [1:0]               state_q, state_d;
  logic                     halt_seen_q, halt_seen_d;
  logic [3:0]               drain_cnt_q, drain_cnt_d;
  logic [N_BITS_CYCLES-1:0] count_q, count_d;
  logic                     aborted_q, aborted_d;
  logic                     dump_req_q, dump_req_d;
  logic                     pipe_reset_q, pipe_reset_d;

  logic w_enable;
  logic w_cmd_fire;
  logic w_drain_done;

  assign w_enable   = (state_q == c_ST_RUN) || (state_q == c_ST_STEP);
  assign w_cmd_fire = i_cmd_valid && o_cmd_ready;

  always_comb begin
    state_d      = state_q;
    halt_seen_d  = halt_seen_q;
    drain_cnt_d  = drain_cnt_q;
    count_d      = count_q;
    aborted_d    = aborted_q;
    pipe_reset_d = 1'b0;
    w_drain_done = 1'b0;

    if (w_enable) begin
      if (count_q != {N_BITS_CYCLES{1'b1}}) begin
        count_d = count_q + 1'b1;
      end
      if (halt_seen_q) begin
        if (drain_cnt_q == 4'd1) begin
          w_drain_done = 1'b1;
          drain_cnt_d  = 4'd0;
        end else if (drain_cnt_q != 4'd0) begin
          drain_cnt_d = drain_cnt_q - 4'd1;
        end
      end else if (i_instr_valid && (i_instruccion == HALT_WORD)) begin
        halt_seen_d = 1'b1;
        drain_cnt_d = c_DRAIN_INIT;
      end
    end

    case (state_q)
      c_ST_IDLE: begin
        if (w_cmd_fire && (i_cmd == c_CMD_RUN)) begin
          state_d = c_ST_RUN;
        end else if (w_cmd_fire && (i_cmd == c_CMD_STEP)) begin
          state_d = c_ST_STEP;
        end
      end
      c_ST_RUN: begin
        // An abort outranks a drain completing in the same cycle
        if (w_cmd_fire && (i_cmd == c_CMD_ABORT)) begin
          state_d   = c_ST_DONE;
          aborted_d = 1'b1;
        end else if (w_drain_done) begin
          state_d   = c_ST_DONE;
          aborted_d = 1'b0;
        end
      end
      c_ST_STEP: begin
        state_d = w_drain_done ? c_ST_DONE : c_ST_IDLE;
      end
      default: begin
        if (w_cmd_fire && (i_cmd == c_CMD_ABORT)) begin
          state_d      = c_ST_IDLE;
          halt_seen_d  = 1'b0;
          drain_cnt_d  = 4'd0;
          count_d      = '0;
          aborted_d    = 1'b0;
          pipe_reset_d = 1'b1;
        end
      end
    endcase

    // A step that completes the drain produces a single dump pulse, not two
    dump_req_d = (state_q == c_ST_STEP) ||
                 ((state_d == c_ST_DONE) && (state_q != c_ST_DONE));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= c_ST_IDLE;
      halt_seen_q  <= 1'b0;
      drain_cnt_q  <= 4'd0;
      count_q      <= '0;
      aborted_q    <= 1'b0;
      dump_req_q   <= 1'b0;
      pipe_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      halt_seen_q  <= halt_seen_d;
      drain_cnt_q  <= drain_cnt_d;
      count_q      <= count_d;
      aborted_q    <= aborted_d;
      dump_req_q   <= dump_req_d;
      pipe_reset_q <= pipe_reset_d;
    end
  end

  assign o_pipe_enable  = w_enable;
  assign o_fetch_enable = w_enable && !halt_seen_q;
  assign o_busy         = w_enable;
  assign o_done         = (state_q == c_ST_DONE);
  assign o_cmd_ready    = (state_q != c_ST_STEP);
  assign o_aborted      = aborted_q;
  assign o_dump_req     = dump_req_q;
  assign o_pipe_reset   = pipe_reset_q;
  assign o_cycle_count  = count_q;
  assign o_state        = state_q;

endmodule

`default_nettype wire

// File: tb/tb_execution_controller.sv
// ============================================================================
// tb_execution_controller : directed scoreboard bench for execution_controller
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_execution_controller;

  localparam logic [31:0] c_HALT = 32'hFFFF_FFFF;
  localparam logic [1:0]  c_IDLE = 2'b00;
  localparam logic [1:0]  c_RUN  = 2'b01;
  localparam logic [1:0]  c_STEP = 2'b10;
  localparam logic [1:0]  c_DONE = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cmd_valid;
  logic [1:0]  i_cmd;
  logic        o_cmd_ready;
  logic        i_instr_valid;
  logic [31:0] i_instruccion;
  logic        o_pipe_enable;
  logic        o_fetch_enable;
  logic        o_pipe_reset;
  logic        o_busy;
  logic        o_done;
  logic        o_aborted;
  logic        o_dump_req;
  logic [31:0] o_cycle_count;
  logic [1:0]  o_state;

  int checks = 0;
  int errors = 0;

  // kind: 0 = dump_req pulse, 1 = pipe_reset pulse
  typedef struct packed {
    logic        kind;
    logic [1:0]  state;
    logic [31:0] count;
    logic        aborted;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  execution_controller #(
    .N_BITS        (32),
    .N_BITS_CYCLES (32),
    .HALT_WORD     (32'hFFFF_FFFF),
    .DRAIN_CYCLES  (4)
  ) u_dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_cmd_valid    (i_cmd_valid),
    .i_cmd          (i_cmd),
    .o_cmd_ready    (o_cmd_ready),
    .i_instr_valid  (i_instr_valid),
    .i_instruccion  (i_instruccion),
    .o_pipe_enable  (o_pipe_enable),
    .o_fetch_enable (o_fetch_enable),
    .o_pipe_reset   (o_pipe_reset),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_aborted      (o_aborted),
    .o_dump_req     (o_dump_req),
    .o_cycle_count  (o_cycle_count),
    .o_state        (o_state)
  );

  // Every dump/pipe_reset pulse must match the next queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (o_dump_req || o_pipe_reset) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: dump=%0b prst=%0b state=%0d count=%0d, required no pulse",
                 o_dump_req, o_pipe_reset, o_state, o_cycle_count);
      end else begin
        e = sb_q.pop_front();
        if ((o_pipe_reset !== e.kind) || (o_dump_req !== !e.kind) ||
            (o_state !== e.state) || (o_cycle_count !== e.count) ||
            (o_aborted !== e.aborted)) begin
          errors++;
          $display("FAIL sb_pulse: got prst=%0b dump=%0b state=%0d count=%0d ab=%0b, required prst=%0b state=%0d count=%0d ab=%0b",
                   o_pipe_reset, o_dump_req, o_state, o_cycle_count, o_aborted,
                   e.kind, e.state, e.count, e.aborted);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] c);
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    tick();
    i_cmd_valid = 1'b0;
    i_cmd       = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic kind, input logic [1:0] st, input logic [31:0] cnt, input logic ab);
    exp_t e;
    e.kind = kind; e.state = st; e.count = cnt; e.aborted = ab;
    sb_q.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(o_state), 32'(c_IDLE));
    chk({tag, "_pipe_en"}, 32'(o_pipe_enable), 0);
    chk({tag, "_fetch_en"}, 32'(o_fetch_enable), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_aborted"}, 32'(o_aborted), 0);
    chk({tag, "_dump"}, 32'(o_dump_req), 0);
    chk({tag, "_prst"}, 32'(o_pipe_reset), 0);
    chk({tag, "_count"}, o_cycle_count, 0);
    chk({tag, "_ready"}, 32'(o_cmd_ready), 1);
  endtask

  initial begin
    int en_cnt;
    int fe_cnt;
    rst           = 1'b1;
    i_cmd_valid   = 1'b0;
    i_cmd         = 2'b00;
    i_instr_valid = 1'b0;
    i_instruccion = '0;
    tick();
    do_reset();
    smp();
    chk_reset_outputs("rst");

    // RUN, HALT on the 10th enabled cycle, drain of 4
    push(1'b0, c_DONE, 32'd14, 1'b0);
    cmd(2'b01);
    en_cnt = 0;
    fe_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      i_instr_valid = 1'b1;
      i_instruccion = (k == 10) ? c_HALT : 32'(k);
      smp();
      if (k == 2) chk("run_ready", 32'(o_cmd_ready), 1);
      if (k == 11) chk("run_fetch_c11", 32'(o_fetch_enable), 0);
      if (o_pipe_enable) en_cnt++;
      if (o_fetch_enable) fe_cnt++;
      tick();
    end
    i_instr_valid = 1'b0;
    chk("run_en_cycles", 32'(en_cnt), 14);
    chk("run_fetch_cycles", 32'(fe_cnt), 10);
    smp();
    chk("run_state", 32'(o_state), 32'(c_DONE));
    chk("run_done", 32'(o_done), 1);
    chk("run_aborted", 32'(o_aborted), 0);
    chk("run_count", o_cycle_count, 14);

    push(1'b1, c_IDLE, 32'd0, 1'b0);
    cmd(2'b11);
    smp();
    chk("clr_state", 32'(o_state), 32'(c_IDLE));
    chk("clr_count", o_cycle_count, 0);
    tick();

    // STEP x3, no HALT
    for (int i = 1; i <= 3; i++) begin
      push(1'b0, c_IDLE, 32'(i), 1'b0);
      cmd(2'b10);
      smp();
      chk("step_ready", 32'(o_cmd_ready), 0);
      chk("step_en", 32'(o_pipe_enable), 1);
      chk("step_state", 32'(o_state), 32'(c_STEP));
      tick();
      smp();
      chk("step_en_after", 32'(o_pipe_enable), 0);
      tick();
    end
    chk("step3_count", o_cycle_count, 3);
    chk("step3_state", 32'(o_state), 32'(c_IDLE));

    // STEP through a HALT fetched on step 2
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      if (k < 6) push(1'b0, c_IDLE, 32'(k), 1'b0);
      else       push(1'b0, c_DONE, 32'd6, 1'b0);
      cmd(2'b10);
      i_instr_valid = 1'b1;
      i_instruccion = (k == 2) ? c_HALT : 32'h0000_0013;
      smp();
      if (k == 3) chk("sdrain_fetch", 32'(o_fetch_enable), 0);
      tick();
      i_instr_valid = 1'b0;
      tick();
    end
    smp();
    chk("sdrain_state", 32'(o_state), 32'(c_DONE));
    chk("sdrain_count", o_cycle_count, 6);
    chk("sdrain_aborted", 32'(o_aborted), 0);
    push(1'b1, c_IDLE, 32'd0, 1'b0);
    cmd(2'b11);
    tick();

    // RUN then ABORT after 5 enabled cycles
    push(1'b0, c_DONE, 32'd5, 1'b1);
    cmd(2'b01);
    repeat (4) tick();
    cmd(2'b11);
    smp();
    chk("abort_state", 32'(o_state), 32'(c_DONE));
    chk("abort_aborted", 32'(o_aborted), 1);
    chk("abort_count", o_cycle_count, 5);
    chk("abort_en", 32'(o_pipe_enable), 0);
    cmd(2'b01);
    smp();
    chk("done_ignores_run", 32'(o_state), 32'(c_DONE));
    push(1'b1, c_IDLE, 32'd0, 1'b0);
    cmd(2'b11);
    smp();
    chk("abort2_state", 32'(o_state), 32'(c_IDLE));
    chk("abort2_prst", 32'(o_pipe_reset), 1);
    chk("abort2_aborted", 32'(o_aborted), 0);
    tick();
    smp();
    chk("abort2_prst_end", 32'(o_pipe_reset), 0);

    // Reset in RUN with halt_seen set
    cmd(2'b01);
    i_instr_valid = 1'b1;
    i_instruccion = c_HALT;
    tick();
    i_instr_valid = 1'b0;
    smp();
    chk("hs_fetch", 32'(o_fetch_enable), 0);
    chk("hs_pipe", 32'(o_pipe_enable), 1);
    do_reset();
    smp();
    chk_reset_outputs("midrun_rst");
    cmd(2'b01);
    repeat (2) tick();
    smp();
    chk("rerun_count", o_cycle_count, 2);
    chk("rerun_fetch", 32'(o_fetch_enable), 1);
    do_reset();

    // IDLE ignores 00/ABORT; HALT without instr_valid is not detected
    i_instr_valid = 1'b0;
    i_instruccion = c_HALT;
    cmd(2'b00);
    cmd(2'b11);
    smp();
    chk("idle_state", 32'(o_state), 32'(c_IDLE));
    chk("idle_pipe", 32'(o_pipe_enable), 0);
    chk("idle_count", o_cycle_count, 0);
    cmd(2'b01);
    repeat (3) tick();
    smp();
    chk("novalid_fetch", 32'(o_fetch_enable), 1);
    chk("novalid_state", 32'(o_state), 32'(c_RUN));
    do_reset();

    repeat (3) tick();
    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
